wide_word_serializer: RTL and testbench

- Downstream stage of the generated 100-bit top-level pipeline; consumes its `__out0` word stream.
- Buffers whole words in a small FIFO, then serialises each word into fixed-width chunks, MSB chunk first, on a valid/ready output interface.
- Decouples the upstream's one-word-per-clock, no-backpressure output from a narrower, stallable consumer.
- Loss of data on overflow is flagged, never silent.

---
 rtl/wide_word_serializer_if.sv | 27 ++
 rtl/wide_word_serializer.sv | 123 ++++++++++++
 tb/tb_wide_word_serializer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wide_word_serializer_if.sv
// Word-in / chunk-out bus of the wide word serializer, with status outputs.
// The slave view belongs to the serializer, the master view to whoever drives it.
`timescale 1ns/1ps
interface wide_word_serializer_if #(
    parameter int IN_W  = 100,
    parameter int OUT_W = 25,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic [IN_W-1:0]          in_data;
    logic                     out_ready;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, fifo_count, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, fifo_count, overflow
    );
endinterface

// File: rtl/wide_word_serializer.sv
// Buffers full-width words in a small FIFO and emits each one as OUT_W-bit chunks,
// most significant chunk first, on a valid/ready stream. Dropped words set a sticky flag.
`timescale 1ns/1ps
module wide_word_serializer #(
    parameter int IN_W  = 100,
    parameter int OUT_W = 25,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    wide_word_serializer_if.slave  bus
);
    localparam int BEATS = IN_W / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_word;
    logic [BW-1:0]     r_beat;
    logic              r_last;

    logic [IN_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_fire;
    logic              w_empty;
    logic              w_full;
    logic              w_load;
    logic              w_advance;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_fire      = (r_state == ST_SEND) && bus.out_ready;
        w_empty     = (r_count == '0);
        w_full      = (r_count == CW'(DEPTH));
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // Accepting the last chunk reloads on the same edge so words abut.
                if (w_fire) begin
                    if (r_last) begin
                        if (!w_empty) w_load      = 1'b1;
                        else          w_state_nxt = ST_IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_pop  = w_load;
        w_push = bus.in_valid && (!w_full || w_pop);
        w_drop = bus.in_valid && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_beat  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_word <= r_mem[r_rptr];
                r_beat <= '0;
                r_last <= (BEATS == 1);
            end else if (w_advance) begin
                r_word <= r_word << OUT_W;
                r_beat <= r_beat + BW'(1);
                r_last <= (r_beat == BW'(BEATS - 2));
            end else if (w_state_nxt == ST_IDLE) begin
                r_last <= 1'b0;
            end
        end
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign bus.out_valid  = (r_state == ST_SEND);
    assign bus.out_data   = r_word[IN_W-1 -: OUT_W];
    assign bus.out_last   = r_last;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_wide_word_serializer.sv
// Directed bench for wide_word_serializer: reset, single word, back-to-back,
// stall, full FIFO with concurrent pop, overflow and mid-word reset.
`timescale 1ns/1ps
module tb_wide_word_serializer;
    localparam int IN_W  = 100;
    localparam int OUT_W = 25;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    wide_word_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    wide_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word whose four chunks, MSB first, are base, base+1, base+2, base+3.
    function automatic logic [IN_W-1:0] mkw(input int base);
        return {25'(base), 25'(base + 1), 25'(base + 2), 25'(base + 3)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%0b exp=0", bus.out_last); end
        n_cmp++; if (bus.out_data !== 25'd0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.overflow); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        logic [24:0] exp [4];
        exp = '{25'h1, 25'h2, 25'h3, 25'h4};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {25'h1, 25'h2, 25'h3, 25'h4};
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_lat_count got=%0d exp=1", bus.fifo_count); end
        step();
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d] got=%0b exp=1", b, bus.out_valid); end
            n_cmp++; if (bus.out_data !== exp[b]) begin n_bad++; $display("FAIL single_data[%0d] got=%h exp=%h", b, bus.out_data, exp[b]); end
            n_cmp++; if (bus.out_last !== (b == 3)) begin n_bad++; $display("FAIL single_last[%0d] got=%0b exp=%0b", b, bus.out_last, (b == 3)); end
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_end_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_end_count got=%0d exp=0", bus.fifo_count); end
    endtask

    task automatic test_back_to_back();
        logic [24:0] exp [8];
        exp = '{25'hA0, 25'hA1, 25'hA2, 25'hA3, 25'hB0, 25'hB1, 25'hB2, 25'hB3};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {25'hA0, 25'hA1, 25'hA2, 25'hA3};
        step();
        bus.in_data   = {25'hB0, 25'hB1, 25'hB2, 25'hB3};
        step();
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", k, bus.out_valid); end
            n_cmp++; if (bus.out_data !== exp[k]) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, bus.out_data, exp[k]); end
            n_cmp++; if (bus.out_last !== (k == 3 || k == 7)) begin n_bad++; $display("FAIL b2b_last[%0d] got=%0b exp=%0b", k, bus.out_last, (k == 3 || k == 7)); end
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {25'hA0, 25'hA1, 25'hA2, 25'hA3};
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got=%0b exp=1", c, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 25'hA2) begin n_bad++; $display("FAIL stall_data[%0d] got=%h exp=a2", c, bus.out_data); end
            n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL stall_last[%0d] got=%0b exp=0", c, bus.out_last); end
            step();
        end
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.out_data !== 25'hA2) begin n_bad++; $display("FAIL stall_release_data got=%h exp=a2", bus.out_data); end
        step();
        n_cmp++; if (bus.out_data !== 25'hA3) begin n_bad++; $display("FAIL stall_resume_data got=%h exp=a3", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b1) begin n_bad++; $display("FAIL stall_resume_last got=%0b exp=1", bus.out_last); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_end_valid got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_full_concurrent_pop();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mkw(256 + 4 * i);
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", bus.fifo_count); end
        n_cmp++; if (bus.out_data !== 25'd256) begin n_bad++; $display("FAIL full_head_data got=%0d exp=256", bus.out_data); end
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        n_cmp++; if (bus.out_last !== 1'b1 || bus.out_data !== 25'd259) begin n_bad++; $display("FAIL full_lastbeat got=%0d/%0b exp=259/1", bus.out_data, bus.out_last); end
        bus.in_valid = 1'b1;
        bus.in_data  = mkw(276);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_pushpop_count got=%0d exp=4", bus.fifo_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL full_pushpop_ovf got=%0b exp=0", bus.overflow); end
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL full_drain_valid[%0d] got=%0b exp=1", k, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 25'(260 + k)) begin n_bad++; $display("FAIL full_drain_data[%0d] got=%0d exp=%0d", k, bus.out_data, 260 + k); end
            n_cmp++; if (bus.out_last !== (k % 4 == 3)) begin n_bad++; $display("FAIL full_drain_last[%0d] got=%0b exp=%0b", k, bus.out_last, (k % 4 == 3)); end
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_end_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL full_end_count got=%0d exp=0", bus.fifo_count); end
    endtask

    task automatic test_overflow();
        int exp_cnt [7];
        logic exp_ovf [7];
        exp_cnt = '{1, 1, 2, 3, 4, 4, 4};
        exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mkw(512 + 4 * i);
            step();
            n_cmp++; if (bus.fifo_count !== 3'(exp_cnt[i])) begin n_bad++; $display("FAIL ovf_count[%0d] got=%0d exp=%0d", i, bus.fifo_count, exp_cnt[i]); end
            n_cmp++; if (bus.overflow !== exp_ovf[i]) begin n_bad++; $display("FAIL ovf_flag[%0d] got=%0b exp=%0b", i, bus.overflow, exp_ovf[i]); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_drain_valid[%0d] got=%0b exp=1", k, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 25'(512 + k)) begin n_bad++; $display("FAIL ovf_drain_data[%0d] got=%0d exp=%0d", k, bus.out_data, 512 + k); end
            n_cmp++; if (bus.out_last !== (k % 4 == 3)) begin n_bad++; $display("FAIL ovf_drain_last[%0d] got=%0b exp=%0b", k, bus.out_last, (k % 4 == 3)); end
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_end_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%0b exp=1", bus.overflow); end
    endtask

    task automatic test_midword_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mkw(1024);
        step();
        bus.in_data   = mkw(1028);
        step();
        bus.in_valid  = 1'b0;
        step();
        n_cmp++; if (bus.out_data !== 25'd1025) begin n_bad++; $display("FAIL mid_pre_data got=%0d exp=1025", bus.out_data); end
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_bad++; $display("FAIL mid_pre_count got=%0d exp=1", bus.fifo_count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_rst_count got=%0d exp=0", bus.fifo_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovf got=%0b exp=0", bus.overflow); end
        n_cmp++; if (bus.out_data !== 25'd0) begin n_bad++; $display("FAIL mid_rst_data got=%0d exp=0", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL mid_rst_last got=%0b exp=0", bus.out_last); end
        step();
        step();
        rst = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = mkw(2048);
        step();
        bus.in_valid = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_new_valid[%0d] got=%0b exp=1", b, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 25'(2048 + b)) begin n_bad++; $display("FAIL mid_new_data[%0d] got=%0d exp=%0d", b, bus.out_data, 2048 + b); end
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_new_end_valid got=%0b exp=0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_full_concurrent_pop();
        test_overflow();
        test_midword_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
